// File: rtl/seg_scan_pkg.sv
// Shared types and glyph table for the two-digit seven-segment scan driver.
package seg_scan_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        S_LEFT    = 2'd0,
        S_BLANK_L = 2'd1,
        S_RIGHT   = 2'd2,
        S_BLANK_R = 2'd3
    } scan_state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low hex glyphs, bit order g..a (seg[0] = a).
    localparam logic [SEG_W-1:0] SEG_HEX_LUT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex to active-low seven-segment glyph lookup.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [SEG_W-1:0]   seg_o
);

    assign seg_o = SEG_HEX_LUT[digit_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver with blanking between digits.
// Digits are captured only on entry to their on-window to avoid torn glyphs.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 7500,
    parameter int unsigned BLANK_CYCLES = 150
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_en,
    input  logic [DIGIT_W-1:0] digit_left,
    input  logic [DIGIT_W-1:0] digit_right,
    output logic [SEG_W-1:0]   seg,
    output logic               select0,
    output logic               select1
);

    localparam int unsigned CNT_W     = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int unsigned ON_CYCLES = PHASE_CYCLES - BLANK_CYCLES;
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] cur_digit_q, cur_digit_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               select0_q, select0_d;
    logic               select1_q, select1_d;
    logic [SEG_W-1:0]   glyph_c;
    logic               last_c;

    // Glyph is decoded from the next-state digit so it lands with the state change.
    seg_hex_decode u_decode (
        .digit_i (cur_digit_d),
        .seg_o   (glyph_c)
    );

    // Next-state: dwell counter, phase sequencing and digit capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        cur_digit_d = cur_digit_q;
        last_c      = 1'b0;

        case (state_q)
            S_LEFT, S_RIGHT: last_c = (cnt_q == ON_LAST);
            default:         last_c = (cnt_q == BLANK_LAST);
        endcase

        if (last_c) begin
            cnt_d = '0;
            case (state_q)
                S_LEFT:    state_d = S_BLANK_L;
                S_BLANK_L: begin
                    state_d     = S_RIGHT;
                    cur_digit_d = digit_right;
                end
                S_RIGHT:   state_d = S_BLANK_R;
                S_BLANK_R: begin
                    state_d     = S_LEFT;
                    cur_digit_d = digit_left;
                end
                default:   state_d = S_BLANK_R;
            endcase
        end
    end

    // Output gating: selects only in on-windows with the display enabled.
    always_comb begin
        select0_d = disp_en && (state_d == S_LEFT);
        select1_d = disp_en && (state_d == S_RIGHT);
        seg_d     = (select0_d || select1_d) ? glyph_c : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_BLANK_R;
            cnt_q       <= '0;
            cur_digit_q <= '0;
            seg_q       <= SEG_BLANK;
            select0_q   <= 1'b0;
            select1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_digit_q <= cur_digit_d;
            seg_q       <= seg_d;
            select0_q   <= select0_d;
            select1_q   <= select1_d;
        end
    end

    assign seg     = seg_q;
    assign select0 = select0_q;
    assign select1 = select1_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: position-in-period reference model checked every
// cycle, plus directed scenarios with literal glyph expectations.
module tb_seg_scan_driver;

    localparam int P   = 10;
    localparam int B   = 2;
    localparam int ON  = P - B;
    localparam int PER = 2 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       disp_en = 1'b1;
    logic [3:0] digit_left = 4'd3;
    logic [3:0] digit_right = 4'd0;
    logic [6:0] seg;
    logic       select0;
    logic       select1;

    int checks = 0;
    int errors = 0;

    logic [6:0] ref_lut [16];

    // Reference model: position within a 2*P period, 0 = first LEFT clock.
    int         m_pos = 0;
    int         m_cur = 0;
    logic       m_en;
    logic       e_sel0, e_sel1;
    logic [6:0] e_seg;

    seg_scan_driver #(
        .PHASE_CYCLES (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .disp_en     (disp_en),
        .digit_left  (digit_left),
        .digit_right (digit_right),
        .seg         (seg),
        .select0     (select0),
        .select1     (select1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos = PER - B;
            m_cur = 0;
        end else begin
            m_pos = (m_pos + 1) % PER;
            if (m_pos == 0)      m_cur = int'(digit_left);
            else if (m_pos == P) m_cur = int'(digit_right);
        end
        m_en = rst_n ? disp_en : 1'b0;
        #1;
        e_sel0 = m_en && (m_pos < ON);
        e_sel1 = m_en && (m_pos >= P) && (m_pos < P + ON);
        e_seg  = (e_sel0 || e_sel1) ? ref_lut[m_cur] : 7'h7F;
        chk("model", 32'({seg, select0, select1}), 32'({e_seg, e_sel0, e_sel1}));
        chk("select_excl", 32'(select0 & select1), 32'd0);
    end

    // Wait (at negedges) for a 0->1 transition of the chosen select, bounded.
    task automatic wait_rise(input int which);
        int n;
        n = 0;
        while (((which == 0) ? select0 : select1) !== 1'b0 && n < 60) begin step(1); n++; end
        while (((which == 0) ? select0 : select1) !== 1'b1 && n < 60) begin step(1); n++; end
        chk("wait_rise_timeout", 32'(n >= 60), 32'd0);
    endtask

    task automatic release_seq();
        rst_n = 1'b1;
        step(1);
        chk("rel_edge1_sel0", 32'(select0), 32'd0);
        step(1);
        for (int i = 0; i < ON; i++) begin
            chk("rel_left_seg", 32'(seg), 32'(7'b0110000));
            chk("rel_left_sel0", 32'(select0), 32'd1);
            step(1);
        end
        chk("rel_blank_sel0", 32'(select0), 32'd0);
    endtask

    initial begin
        int n;
        logic prev;
        ref_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset hold and first phase
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_sel", 32'({select0, select1}), 32'd0);
        end
        release_seq();

        // Full sweep and period
        digit_left  = 4'hA;
        digit_right = 4'h5;
        wait_rise(0);
        wait_rise(0);
        chk("sweep_left_A", 32'(seg), 32'(7'b0001000));
        n = 0;
        prev = select0;
        do begin
            step(1);
            n++;
            if (select0 === 1'b1 && prev === 1'b0) break;
            prev = select0;
        end while (n < 60);
        chk("period", 32'(n), 32'(PER));
        wait_rise(1);
        chk("sweep_right_5", 32'(seg), 32'(7'b0010010));

        // No tearing: change right digit at count 3 of RIGHT
        wait_rise(1);
        step(3);
        digit_right = 4'hF;
        for (int i = 0; i < ON - 3; i++) begin
            chk("no_tear", 32'(seg), 32'(7'b0010010));
            step(1);
        end
        chk("no_tear_end_sel1", 32'(select1), 32'd0);
        wait_rise(1);
        chk("right_F", 32'(seg), 32'(7'b0001110));

        // Enable gating during LEFT
        wait_rise(0);
        step(2);
        disp_en = 1'b0;
        step(1);
        chk("en_off_seg", 32'(seg), 32'h7F);
        chk("en_off_sel", 32'({select0, select1}), 32'd0);
        step(2);
        disp_en = 1'b1;
        step(1);
        chk("en_on_sel0", 32'(select0), 32'd1);
        chk("en_on_seg", 32'(seg), 32'(7'b0001000));
        step(1);
        chk("en_count7_sel0", 32'(select0), 32'd1);
        step(1);
        chk("en_blank_sel0", 32'(select0), 32'd0);

        // Mid-phase reset at count 4 of RIGHT
        wait_rise(1);
        step(4);
        rst_n = 1'b0;
        digit_left = 4'd3;
        step(1);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_sel", 32'({select0, select1}), 32'd0);
        step(2);
        release_seq();

        // Hex coverage on the left digit
        for (int v = 0; v < 16; v++) begin
            digit_left = 4'(v);
            wait_rise(0);
            chk("hex_glyph", 32'(seg), 32'(ref_lut[v]));
        end

        // Randomized traffic: model compares every cycle
        for (int i = 0; i < 800; i++) begin
            digit_left  = 4'($urandom_range(0, 15));
            digit_right = 4'($urandom_range(0, 15));
            disp_en     = ($urandom_range(0, 7) != 0);
            rst_n       = ($urandom_range(0, 149) != 0);
            step(1);
        end
        rst_n = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment driver for the two-digit display, directly downstream of `keypad_controller`. It consumes `digit_left`/`digit_right`, hex-decodes them and alternately powers each display. A blanking interval between digits suppresses ghosting. Each digit is captured only at the start of its on-window, so controller updates never tear a displayed glyph.

## Interface
- `PHASE_CYCLES`, default 7500: clocks per digit phase (on + blank). At 3 MHz this gives 200 Hz per digit. Must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 150: clocks per phase with both selects off. Must be ≥ 1.
- `clk` input, 1 bit: single system clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `disp_en` input, 1 bit: 1 shows digits; 0 forces display dark while the scan keeps running.
- `digit_left` input, 4 bits: hex value for the left display.
- `digit_right` input, 4 bits: hex value for the right display.
- `seg` output, 7 bits: segment drive, active-low; `seg[0]`=a … `seg[6]`=g.
- `select0` output, 1 bit: left display power, active-high.
- `select1` output, 1 bit: right display power, active-high.

## Operation
- FSM states: `S_LEFT`, `S_BLANK_L`, `S_RIGHT`, `S_BLANK_R`. The cycle order is LEFT → BLANK_L → RIGHT → BLANK_R → LEFT.
- Dwell times:
  - `S_LEFT` and `S_RIGHT` each last `ON = PHASE_CYCLES - BLANK_CYCLES` clocks.
  - Blank states each last `BLANK_CYCLES` clocks.
- Phase counter:
  - Width `$clog2(PHASE_CYCLES)`.
  - Counts 0 … dwell-1 within a state.
  - On the terminal count, the state advances and the counter clears.
- Digit capture:
  - On the edge entering `S_LEFT`, `digit_left` is latched into `cur_digit`.
  - On the edge entering `S_RIGHT`, `digit_right` is latched into `cur_digit`.
  - `cur_digit` holds for the whole on-window.
- Segment decoding uses standard hex glyphs, active-low, written as g..a:
  - 0 = 1000000
  - 1 = 1111001
  - 8 = 0000000
  - A = 0001000
  - F = 0001110
- Output rules:
  - In blank states, or when `disp_en`=0: `seg` = 7'h7F and `select0` = `select1` = 0.
  - `select0` and `select1` are never 1 in the same cycle.
  - `seg` is 7'h7F whenever both selects are 0.
- `disp_en` does not affect the FSM, the counter or digit capture. It only gates the outputs.

## Timing
- All outputs are registered and computed from next-state. The output change appears on the same edge as the state change.
- Reset:
  - Every edge with `rst_n`=0 sets state `S_BLANK_R`, counter 0, `cur_digit` 0, `seg` 7'h7F and `select0` = `select1` = 0.
  - Reset mid-phase aborts immediately, with the same values.
- After release:
  - The first edge with `rst_n`=1 is count 0 of `S_BLANK_R`.
  - `select0` rises on edge number `BLANK_CYCLES` after release.
- Full period: `2*PHASE_CYCLES` clocks. `select0` and `select1` are each high exactly `ON` clocks per period.
- Input-change latency:
  - A `digit_left` change appears at the next `S_LEFT` entry, worst case `2*PHASE_CYCLES` clocks.
  - An input change on the capture edge itself is taken.
- `disp_en` latency: a change is reflected on `seg` and the selects on the next edge.
- Boundary case: with `BLANK_CYCLES = PHASE_CYCLES - 1`, `ON` = 1 and each select pulses for a single clock. This must still work.

## Structure
- Package `seg_scan_pkg` holds:
  - The enum typedef `scan_state_t`.
  - The constant `SEG_HEX_LUT [16][7]` with the active-low glyphs.
  - `SEG_BLANK = 7'h7F`.
- Sub-module `seg_hex_decode`: combinational, 4-bit to 7-bit lookup from `SEG_HEX_LUT`. It is shared with any future display path.
- Top-level integration: this block replaces the display instance in the lab top. `rst_n` connects directly, with no inversion.

## Test plan
Bench runs with `PHASE_CYCLES=10` and `BLANK_CYCLES=2`.
- **Reset and first phase:** hold `rst_n`=0 for 5 clocks with `digit_left`=3 → `seg`=7F and selects 00 throughout. Release → after 2 clocks, `select0`=1 and `seg`=0110000 for 8 clocks.
- **Full sweep:** left=A, right=5, `disp_en`=1 → the period is 20 clocks. Check the sequence LEFT(8, A=0001000), blank(2), RIGHT(8, 5=0010010), blank(2). The selects are never both 1.
- **No tearing:** change `digit_right` from 5 to F at count 3 of `S_RIGHT` → `seg` stays 0010010 until the window ends. F=0001110 appears at the next `S_RIGHT`.
- **Enable gating:** drop `disp_en` during `S_LEFT` → next edge `seg`=7F and selects 00. Restore it → the glyph returns at the same FSM position, with phase timing unchanged.
- **Mid-phase reset:** assert `rst_n`=0 at count 4 of `S_RIGHT` → next edge shows reset values. The post-release sequence is identical to the first scenario.
- **Hex coverage:** step `digit_left` through 0–F, one value per period → every glyph matches `SEG_HEX_LUT`.
